// File: rtl/vga_pkg.sv
// Shared VGA timing package.
// Holds the 640x480@60 timing constants, the derived sync window bounds and
// the coordinate type used by the raster generator, colour mapper and board
// renderer.
package vga_pkg;

  localparam int COORD_W   = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Inclusive sync windows: HS low for 656..751, VS low for 490..491.
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-MOD counter with enable.
// Ports:
//   Clk   - system clock
//   Reset - asynchronous active-high reset, clears count
//   en    - advance the count on this Clk edge
//   count - current value, 0..MOD-1
//   wrap  - combinational, high when the next enabled edge returns count to 0
module vga_mod_counter
  import vga_pkg::*;
#(
  parameter int MOD = H_TOTAL
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   en,
  output coord_t count,
  output logic   wrap
);

  coord_t r_count;

  assign wrap  = en && (r_count == coord_t'(MOD - 1));
  assign count = r_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source.
// Divides Clk by two into the pixel clock, scans the full raster and drives
// sync, blank and the current pixel coordinate.
// Ports:
//   Clk         - system clock (50 MHz)
//   Reset       - asynchronous active-high reset
//   VGA_CLK     - pixel clock, Clk/2, registered
//   VGA_HS      - horizontal sync, active low
//   VGA_VS      - vertical sync, active low
//   VGA_BLANK_N - 1 in the visible region
//   VGA_SYNC_N  - constant 0 (no sync-on-green)
//   DrawX/DrawY - current pixel column/line
//   frame_start - one-Clk pulse after the raster returns to (0,0)
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   VGA_CLK,
  output logic   VGA_HS,
  output logic   VGA_VS,
  output logic   VGA_BLANK_N,
  output logic   VGA_SYNC_N,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   frame_start
);

  localparam int HT  = H_VIS + H_FP + H_SW + H_BP;
  localparam int VT  = V_VIS + V_FP + V_SW + V_BP;
  localparam int HS0 = H_VIS + H_FP;
  localparam int HS1 = HS0 + H_SW - 1;
  localparam int VS0 = V_VIS + V_FP;
  localparam int VS1 = VS0 + V_SW - 1;

  if (HT > 1024 || VT > 1024) begin : g_bad_timing
    $error("vga_sync_gen: raster totals must fit 10-bit counters");
  end

  logic   r_vga_clk;
  logic   r_hs;
  logic   r_vs;
  logic   r_blank_n;
  logic   r_frame_start;

  logic   w_pix_tick;
  logic   w_h_wrap;
  logic   w_v_wrap;
  coord_t w_hc;
  coord_t w_vc;
  coord_t w_hc_nxt;
  coord_t w_vc_nxt;

  // The tick is the edge where VGA_CLK falls, so all raster state moves on
  // VGA_CLK's falling edge and is stable across its rising edge.
  assign w_pix_tick = r_vga_clk;

  vga_mod_counter #(.MOD(HT)) u_hcnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (w_pix_tick),
    .count (w_hc),
    .wrap  (w_h_wrap)
  );

  vga_mod_counter #(.MOD(VT)) u_vcnt (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (w_h_wrap),
    .count (w_vc),
    .wrap  (w_v_wrap)
  );

  // Counter values after the coming tick; decoding these into registers
  // keeps sync/blank aligned with DrawX/DrawY with no lag.
  assign w_hc_nxt = w_h_wrap ? '0 : w_hc + coord_t'(1);
  assign w_vc_nxt = w_v_wrap ? '0 : (w_h_wrap ? w_vc + coord_t'(1) : w_vc);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vga_clk     <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_vga_clk     <= ~r_vga_clk;
      // A vertical wrap only happens on a tick that also wraps horizontally.
      r_frame_start <= w_v_wrap;
      if (w_pix_tick) begin
        r_hs      <= !((w_hc_nxt >= coord_t'(HS0)) && (w_hc_nxt <= coord_t'(HS1)));
        r_vs      <= !((w_vc_nxt >= coord_t'(VS0)) && (w_vc_nxt <= coord_t'(VS1)));
        r_blank_n <= (w_hc_nxt < coord_t'(H_VIS)) && (w_vc_nxt < coord_t'(V_VIS));
      end
    end
  end

  assign VGA_CLK     = r_vga_clk;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = w_hc;
  assign DrawY       = w_vc;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size horizontal timing, shortened vertical
// timing (4 visible, 2 front, 2 sync, 2 back = 10 lines, 16000 Clk/frame).
module tb_vga_sync_gen;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  logic [9:0] DrawX, DrawY;

  localparam int FRAME_CLK = 16000;

  vga_sync_gen #(.V_VIS(4), .V_FP(2), .V_SW(2), .V_BP(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string name;
    int    n;      // Clk edges since Reset release
    int    hc;
    int    vc;
    bit    vclk;
    bit    hs;
    bit    vs;
    bit    blank;
    bit    fs;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cur;

  function automatic logic [24:0] pk(int hc, int vc, bit vclk, bit hs, bit vs,
                                     bit blank, bit fs);
    return {vclk, hs, vs, blank, fs, 10'(hc), 10'(vc)};
  endfunction

  function automatic logic [24:0] obs();
    return {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, DrawX, DrawY};
  endfunction

  // Expected outputs after Clk edge n following Reset release.
  function automatic logic [24:0] model(int n);
    int t, p, hc, vc;
    t = n / 2;
    if (t == 0) return pk(0, 0, n[0], 1'b1, 1'b1, 1'b0, 1'b0);
    p  = t % 8000;
    hc = p % 800;
    vc = p / 800;
    return pk(hc, vc, n[0], !(hc >= 656 && hc <= 751), !(vc >= 6 && vc <= 7),
              (hc < 640) && (vc < 4), (n % 2 == 0) && (p == 0));
  endfunction

  task automatic chk(string name, logic [24:0] act, logic [24:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(string name, int n, int hc, int vc, bit vclk, bit hs,
                     bit vs, bit blank, bit fs);
    vec_t v;
    v.name = name; v.n = n; v.hc = hc; v.vc = vc; v.vclk = vclk;
    v.hs = hs; v.vs = vs; v.blank = blank; v.fs = fs;
    tbl.push_back(v);
  endtask

  initial begin
    int hs_low, vs_low, blank_hi, fs_hi, bad, first;

    //   name            n      hc   vc  clk hs vs bl fs
    add("edge1_clk",      1,     0,   0, 1, 1, 1, 0, 0);
    add("tick1",          2,     1,   0, 0, 1, 1, 1, 0);
    add("tick1_hold",     3,     1,   0, 1, 1, 1, 1, 0);
    add("last_vis_x",     1278,  639, 0, 0, 1, 1, 1, 0);
    add("first_blank_x",  1280,  640, 0, 0, 1, 1, 0, 0);
    add("hs_fall",        1312,  656, 0, 0, 0, 1, 0, 0);
    add("hs_last_low",    1502,  751, 0, 0, 0, 1, 0, 0);
    add("hs_rise",        1504,  752, 0, 0, 1, 1, 0, 0);
    add("line_end",       1598,  799, 0, 0, 1, 1, 0, 0);
    add("line_wrap",      1600,  0,   1, 0, 1, 1, 1, 0);
    add("last_vis_xy",    6078,  639, 3, 0, 1, 1, 1, 0);
    add("first_blank_y",  6400,  0,   4, 0, 1, 1, 0, 0);
    add("vs_low",         10878, 639, 6, 0, 1, 0, 0, 0);
    add("vs_last_low",    12798, 799, 7, 0, 1, 0, 0, 0);
    add("vs_rise",        12800, 0,   8, 0, 1, 1, 0, 0);
    add("frame_end",      15998, 799, 9, 0, 1, 1, 0, 0);
    add("frame_wrap",     16000, 0,   0, 0, 1, 1, 1, 1);
    add("fs_one_clk",     16001, 0,   0, 1, 1, 1, 1, 0);

    repeat (3) @(negedge Clk);
    chk("reset_state", obs(), pk(0, 0, 0, 1, 1, 0, 0));
    chk("sync_n", {24'd0, VGA_SYNC_N}, 25'd0);
    Reset = 1'b0;
    cur = 0;

    foreach (tbl[i]) begin
      repeat (tbl[i].n - cur) @(posedge Clk);
      cur = tbl[i].n;
      @(negedge Clk);
      chk(tbl[i].name, obs(), pk(tbl[i].hc, tbl[i].vc, tbl[i].vclk, tbl[i].hs,
                                 tbl[i].vs, tbl[i].blank, tbl[i].fs));
    end

    // Full second frame against the model, plus per-frame totals.
    hs_low = 0; vs_low = 0; blank_hi = 0; fs_hi = 0; bad = 0;
    for (int n = cur + 1; n <= cur + FRAME_CLK; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (obs() !== model(n)) begin
        if (bad == 0) $display("FAIL sweep n=%0d: got %h want %h", n, obs(), model(n));
        bad++;
      end
      if (!VGA_HS) hs_low++;
      if (!VGA_VS) vs_low++;
      if (VGA_BLANK_N) blank_hi++;
      if (frame_start) fs_hi++;
    end
    cur = cur + FRAME_CLK;
    chk("sweep_bad_cycles", 25'(bad), 25'd0);
    chk("hs_low_clk", 25'(hs_low), 25'd1920);
    chk("vs_low_clk", 25'(vs_low), 25'd3200);
    chk("blank_hi_clk", 25'(blank_hi), 25'd5120);
    chk("frame_start_count", 25'(fs_hi), 25'd1);

    // Mid-frame reset at (700,3), inside the HS pulse.
    repeat (2 * FRAME_CLK + 6200 - cur) @(posedge Clk);
    @(negedge Clk);
    chk("pre_reset_700_3", obs(), pk(700, 3, 0, 0, 1, 0, 0));
    #2 Reset = 1'b1;
    #1 chk("async_reset", obs(), pk(0, 0, 0, 1, 1, 0, 0));
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_held", obs(), pk(0, 0, 0, 1, 1, 0, 0));
    Reset = 1'b0;

    first = 0;
    for (int k = 1; k <= 20000; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (frame_start) begin
        first = k;
        break;
      end
    end
    chk("fs_after_reset", 25'(first), 25'(FRAME_CLK));
    @(posedge Clk);
    @(negedge Clk);
    chk("fs_after_reset_drop", obs(), pk(0, 0, 1, 1, 1, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
